// File: rtl/acq_seq_pkg.sv
// acq_seq_pkg: state encoding, default widths and trig_rst pulse width for acq_sequencer.
package acq_seq_pkg;

  localparam int ACQ_ADDR_W_DEF = 10;
  localparam int ACQ_TMO_W_DEF  = 24;
  localparam int TRIG_RST_PULSE = 1;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_FILL  = 5'b00010,
    ST_ARMED = 5'b00100,
    ST_POST  = 5'b01000,
    ST_DONE  = 5'b10000
  } acq_state_e;

endpackage

// File: rtl/acq_timeout_counter.sv
// acq_timeout_counter: counts enabled cycles and flags expiry on the limit-th cycle (limit 0 = never).
module acq_timeout_counter
  import acq_seq_pkg::*;
#(
  parameter int TMO_W = ACQ_TMO_W_DEF
) (
  input  logic             clk,
  input  logic             module_reset,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [TMO_W-1:0] count;

  // count holds the number of enabled cycles already completed
  assign expired = enable && (limit != '0) && (count == limit - TMO_ONE);

  always_ff @(posedge clk or posedge module_reset) begin
    if (module_reset) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + TMO_ONE;
    end
  end

endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer: pre/post-trigger capture sequencer driving a circular sample buffer.
// Define ACQ_SEQ_TIMEOUT_EN to build the auto-trigger timeout in the ARMED state.
module acq_sequencer
  import acq_seq_pkg::*;
#(
  parameter int ADDR_W = ACQ_ADDR_W_DEF,
  parameter int TMO_W  = ACQ_TMO_W_DEF
) (
  input  logic              clk,
  input  logic              module_reset,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  input  logic [ADDR_W-1:0] pre_count,
  input  logic [ADDR_W-1:0] post_count,
  input  logic [TMO_W-1:0]  tmo_cycles,
  input  logic              trig_in,
  input  logic              rd_ack,
  output logic              armed,
  output logic              trig_rst,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              capture_done,
  output logic              timed_out
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  acq_state_e        state;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [3:0]        rst_left;
  logic              start_block;
  logic              tmo_hit;

`ifdef ACQ_SEQ_TIMEOUT_EN
  acq_timeout_counter #(.TMO_W(TMO_W)) u_timeout (
    .clk          (clk),
    .module_reset (module_reset),
    .enable       (state == ST_ARMED),
    .limit        (tmo_cycles),
    .expired      (tmo_hit)
  );
`else
  logic tmo_unused;
  assign tmo_unused = ^tmo_cycles;
  assign tmo_hit    = 1'b0;
`endif

  // wr_addr is the address written in the current cycle; it only advances between consecutive writes
  always_ff @(posedge clk or posedge module_reset) begin
    if (module_reset) begin
      state        <= ST_IDLE;
      armed        <= 1'b0;
      trig_rst     <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      trig_addr    <= '0;
      capture_done <= 1'b0;
      timed_out    <= 1'b0;
      fill_cnt     <= '0;
      post_cnt     <= '0;
      rst_left     <= '0;
      start_block  <= 1'b1;
    end else begin
      start_block <= 1'b0;
      if (rst_left != '0) begin
        rst_left <= rst_left - 4'd1;
      end else begin
        trig_rst <= 1'b0;
      end

      if (abort) begin
        if (state == ST_DONE) begin
          trig_rst <= 1'b1;
          rst_left <= 4'(TRIG_RST_PULSE - 1);
        end
        state        <= ST_IDLE;
        armed        <= 1'b0;
        wr_en        <= 1'b0;
        capture_done <= 1'b0;
        timed_out    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !start_block) begin
              state     <= ST_FILL;
              fill_cnt  <= '0;
              wr_en     <= (pre_count != '0);
              timed_out <= 1'b0;
            end
          end
          ST_FILL: begin
            if (wr_en) begin
              wr_addr  <= wr_addr + ADDR_ONE;
              fill_cnt <= fill_cnt + ADDR_ONE;
            end
            if (!wr_en || fill_cnt == pre_count - ADDR_ONE) begin
              state <= ST_ARMED;
              armed <= 1'b1;
              wr_en <= 1'b1;
            end
          end
          ST_ARMED: begin
            if (trig_in || tmo_hit) begin
              state     <= ST_POST;
              armed     <= 1'b0;
              trig_addr <= wr_addr;
              post_cnt  <= post_count;
              timed_out <= !trig_in;
              wr_en     <= (post_count != '0);
              if (post_count != '0) begin
                wr_addr <= wr_addr + ADDR_ONE;
              end
            end else begin
              wr_addr <= wr_addr + ADDR_ONE;
            end
          end
          ST_POST: begin
            if (!wr_en || post_cnt == ADDR_ONE) begin
              state        <= ST_DONE;
              wr_en        <= 1'b0;
              capture_done <= 1'b1;
            end else begin
              wr_addr  <= wr_addr + ADDR_ONE;
              post_cnt <= post_cnt - ADDR_ONE;
            end
          end
          ST_DONE: begin
            if (rd_ack) begin
              trig_rst     <= 1'b1;
              rst_left     <= 4'(TRIG_RST_PULSE - 1);
              capture_done <= 1'b0;
              if (continuous) begin
                state    <= ST_FILL;
                fill_cnt <= '0;
                wr_en    <= (pre_count != '0);
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: directed self-checking bench for acq_sequencer (ADDR_W=4).
module tb_acq_sequencer;

  localparam int ADDR_W = 4;
  localparam int TMO_W  = 24;

  logic              clk;
  logic              module_reset;
  logic              start, abort, continuous, trig_in, rd_ack;
  logic [ADDR_W-1:0] pre_count, post_count;
  logic [TMO_W-1:0]  tmo_cycles;
  logic              armed, trig_rst, wr_en, capture_done, timed_out;
  logic [ADDR_W-1:0] wr_addr, trig_addr;

  int tests_run    = 0;
  int tests_failed = 0;
  int n;

  acq_sequencer #(.ADDR_W(ADDR_W), .TMO_W(TMO_W)) dut (
    .clk          (clk),
    .module_reset (module_reset),
    .start        (start),
    .abort        (abort),
    .continuous   (continuous),
    .pre_count    (pre_count),
    .post_count   (post_count),
    .tmo_cycles   (tmo_cycles),
    .trig_in      (trig_in),
    .rd_ack       (rd_ack),
    .armed        (armed),
    .trig_rst     (trig_rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .trig_addr    (trig_addr),
    .capture_done (capture_done),
    .timed_out    (timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // one clock edge; outputs are sampled and inputs driven 1ns after it
  task automatic tick(input int cycles = 1);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] pre, input logic [ADDR_W-1:0] post);
    pre_count  = pre;
    post_count = post;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic waitDone(input int max_cycles, output int cycles);
    cycles = 0;
    while (!capture_done && cycles < max_cycles) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    module_reset = 1'b1;
    start = 0; abort = 0; continuous = 0; trig_in = 0; rd_ack = 0;
    pre_count = '0; post_count = '0; tmo_cycles = '0;
    #3;
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_armed", armed, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_capture_done", capture_done, 0);
    tick(2);
    module_reset = 1'b0;

    // start in the first cycle after reset release must be ignored
    applyStimulus(4'd4, 4'd8);
    checkOutput("start_blocked", wr_en, 0);

    // pre=4 post=8, trigger in 3rd ARMED cycle
    applyStimulus(4'd4, 4'd8);
    checkOutput("fill_wr_en", wr_en, 1);
    checkOutput("fill_first_addr", wr_addr, 0);
    tick(3);
    checkOutput("fill_not_armed", armed, 0);
    tick();
    checkOutput("armed_rise", armed, 1);
    checkOutput("armed_addr", wr_addr, 4);
    tick(2);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    checkOutput("t1_trig_addr", trig_addr, 6);
    checkOutput("t1_armed_low", armed, 0);
    waitDone(50, n);
    checkOutput("t1_post_cycles", n, 8);
    checkOutput("t1_done", capture_done, 1);
    checkOutput("t1_done_addr", wr_addr, 14);
    checkOutput("t1_done_wr_en", wr_en, 0);
    tick();
    checkOutput("t1_addr_held", wr_addr, 14);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    checkOutput("t1_trig_rst", trig_rst, 1);
    checkOutput("t1_done_clear", capture_done, 0);
    tick();
    checkOutput("t1_trig_rst_end", trig_rst, 0);
    checkOutput("t1_idle", wr_en, 0);

    // wrap: start at 14, pre=3 post=5, trigger in first ARMED cycle
    applyStimulus(4'd3, 4'd5);
    checkOutput("t2_first_addr", wr_addr, 14);
    tick(3);
    checkOutput("t2_armed", armed, 1);
    checkOutput("t2_armed_addr", wr_addr, 1);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    checkOutput("t2_trig_addr", trig_addr, 1);
    waitDone(50, n);
    checkOutput("t2_post_cycles", n, 5);
    checkOutput("t2_done_addr", wr_addr, 6);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;

    // abort and trigger together in ARMED
    applyStimulus(4'd2, 4'd2);
    tick(2);
    checkOutput("t3_armed", armed, 1);
    trig_in = 1'b1;
    abort   = 1'b1;
    tick();
    abort   = 1'b0;
    checkOutput("t3_armed_low", armed, 0);
    checkOutput("t3_trig_addr_kept", trig_addr, 1);
    checkOutput("t3_wr_en", wr_en, 0);
    checkOutput("t3_wr_addr", wr_addr, 8);
    tick();
    trig_in = 1'b0;
    checkOutput("t3_idle_trig_ignored", trig_addr, 1);
    checkOutput("t3_idle_wr_en", wr_en, 0);

    // continuous re-arm after readout
    continuous = 1'b1;
    applyStimulus(4'd1, 4'd2);
    tick();
    checkOutput("t4_armed", armed, 1);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    checkOutput("t4_trig_addr", trig_addr, 9);
    waitDone(50, n);
    checkOutput("t4_done_addr", wr_addr, 11);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    checkOutput("t4_trig_rst", trig_rst, 1);
    checkOutput("t4_refill_wr_en", wr_en, 1);
    checkOutput("t4_refill_addr", wr_addr, 11);
    tick();
    checkOutput("t4_trig_rst_end", trig_rst, 0);
    checkOutput("t4_rearmed", armed, 1);
    checkOutput("t4_rearm_addr", wr_addr, 12);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    checkOutput("t4_trig_addr2", trig_addr, 12);
    waitDone(50, n);
    checkOutput("t4_done2", capture_done, 1);
    checkOutput("t4_done_addr2", wr_addr, 14);
    continuous = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t4_abort_trig_rst", trig_rst, 1);
    checkOutput("t4_abort_done_clear", capture_done, 0);

    // pre=0 and post=0 boundaries
    applyStimulus(4'd0, 4'd0);
    checkOutput("t5_no_fill_write", wr_en, 0);
    tick();
    checkOutput("t5_armed", armed, 1);
    checkOutput("t5_armed_wr_en", wr_en, 1);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    checkOutput("t5_no_post_write", wr_en, 0);
    checkOutput("t5_trig_addr", trig_addr, 14);
    waitDone(50, n);
    checkOutput("t5_post_cycles", n, 1);
    checkOutput("t5_done_addr", wr_addr, 14);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;

    // trigger timeout
    tmo_cycles = 24'd100;
    applyStimulus(4'd1, 4'd1);
    tick();
    checkOutput("t6_armed", armed, 1);
    n = 0;
    while (armed && n < 10000) begin
      tick();
      n++;
    end
`ifdef ACQ_SEQ_TIMEOUT_EN
    checkOutput("t6_tmo_cycles", n, 100);
    checkOutput("t6_timed_out", timed_out, 1);
    checkOutput("t6_trig_addr", trig_addr, 2);
    waitDone(50, n);
    checkOutput("t6_done_addr", wr_addr, 3);
`else
    checkOutput("t6_still_armed", armed, 1);
    checkOutput("t6_wait_cycles", n, 10000);
    checkOutput("t6_timed_out", timed_out, 0);
    checkOutput("t6_wr_addr", wr_addr, 15);
`endif
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t6_abort_timed_out", timed_out, 0);
    tmo_cycles = '0;

    // asynchronous reset in the middle of POST
    applyStimulus(4'd2, 4'd8);
    tick(2);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    tick(2);
    checkOutput("t7_in_post", wr_en, 1);
    #2;
    module_reset = 1'b1;
    #1;
    checkOutput("t7_rst_wr_en", wr_en, 0);
    checkOutput("t7_rst_wr_addr", wr_addr, 0);
    checkOutput("t7_rst_trig_addr", trig_addr, 0);
    checkOutput("t7_rst_flags", {armed, trig_rst, capture_done, timed_out}, 0);
    tick(2);
    module_reset = 1'b0;
    applyStimulus(4'd1, 4'd1);
    checkOutput("t7_start_blocked", wr_en, 0);
    applyStimulus(4'd1, 4'd1);
    checkOutput("t7_start_ok", wr_en, 1);
    checkOutput("t7_start_addr", wr_addr, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
